lab2_proc_proc_mem_arbiter: RTL and testbench

LAB2_PROC_PROC_MEM_ARBITER -- requirements
Module: lab2_proc_ProcMemArbiter

---
 rtl/lab2_proc_proc_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_lab2_proc_proc_mem_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_proc_mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant onto one memory port, in-order response routing.
// Latency: zero cycles on both the request path and the response path (purely combinational forwarding).
// Backpressure: requests stall on memreq_rdy low or a full route FIFO; responses stall on the owning requester's rdy.

// Small generic FIFO used here to remember which requester owns each outstanding request.
// Latency: one cycle from push to the entry being visible at the head.
// Backpressure: push is ignored when full and pop when empty; no bypass.
module lab2_proc_route_fifo #(
    parameter int p_width = 1,
    parameter int p_depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [p_width-1:0]       push_dat,
    input  logic                     pop_vld,
    output logic [p_width-1:0]       head_dat,
    output logic [$clog2(p_depth):0] count
);
    localparam int c_ptr_w = $clog2(p_depth);
    localparam int c_cnt_w = $clog2(p_depth) + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(p_depth);

    logic [p_width-1:0] entries [p_depth];
    logic [c_ptr_w-1:0] head_ptr;
    logic [c_ptr_w-1:0] tail_ptr;
    logic               full;
    logic               empty;
    logic               do_push;
    logic               do_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    always_comb begin
        full     = (count == c_full_cnt);
        empty    = (count == '0);
        do_push  = push_vld & ~full;
        do_pop   = pop_vld & ~empty;
        head_dat = entries[head_ptr];
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + c_ptr_w'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + c_ptr_w'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + c_cnt_w'(1);
                2'b01:   count <= count - c_cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[tail_ptr] <= push_dat;
        end
    end
endmodule

// Arbitrates instruction-fetch (0) and data (1) requesters onto a single memory port.
// Latency: zero cycles; grant depends only on the valids and the priority bit.
// Backpressure: full route FIFO or memreq_rdy low stalls requests; response waits for the head owner's rdy.
module lab2_proc_proc_mem_arbiter #(
    parameter int p_max_outstanding = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [76:0] req0_msg,

    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic [76:0] req1_msg,

    output logic        memreq_val,
    input  logic        memreq_rdy,
    output logic [76:0] memreq_msg,

    input  logic        memresp_val,
    output logic        memresp_rdy,
    input  logic [46:0] memresp_msg,

    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [46:0] resp0_msg,

    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [46:0] resp1_msg
);
    // The depth must be a power of two and at least 2 so pointer wrap is free.
    localparam int c_cnt_w = $clog2(p_max_outstanding) + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(p_max_outstanding);

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    logic               prio;
    logic               any_req;
    logic               grant0;
    logic               grant1;
    logic               full;
    logic               empty;
    logic               head_id;
    logic [c_cnt_w-1:0] count;
    logic               req_xfer;
    logic               resp_xfer;
    mem_req_4B_t        fwd_req;
    mem_resp_4B_t       resp_dat;

    // Grant uses only the valids and prio so it never depends on memory readiness.
    always_comb begin
        any_req = req0_val | req1_val;
        grant0  = req0_val & (~req1_val | ~prio);
        grant1  = req1_val & (~req0_val | prio);
        full    = (count == c_full_cnt);
        empty   = (count == '0);
    end

    // Forward the granted request unmodified; everything is held low during reset.
    always_comb begin
        fwd_req = '0;
        if (!reset) begin
            if (grant0) begin
                fwd_req = req0_msg;
            end else if (grant1) begin
                fwd_req = req1_msg;
            end
        end
        memreq_msg = fwd_req;
        memreq_val = any_req & ~full & ~reset;
        req0_rdy   = grant0 & memreq_rdy & ~full & ~reset;
        req1_rdy   = grant1 & memreq_rdy & ~full & ~reset;
        req_xfer   = memreq_val & memreq_rdy;
    end

    // After a transfer the requester that lost (or was idle) gets priority next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (req_xfer) begin
            prio <= grant0;
        end
    end

    lab2_proc_route_fifo #(
        .p_width (1),
        .p_depth (p_max_outstanding)
    ) u_route_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (req_xfer),
        .push_dat (grant1),
        .pop_vld  (resp_xfer),
        .head_dat (head_id),
        .count    (count)
    );

    // Route the memory response to the owner of the oldest outstanding request.
    always_comb begin
        resp0_val   = 1'b0;
        resp1_val   = 1'b0;
        resp0_msg   = '0;
        resp1_msg   = '0;
        memresp_rdy = 1'b0;
        resp_dat    = memresp_msg;
        if (!reset && !empty) begin
            if (head_id) begin
                resp1_val   = memresp_val;
                resp1_msg   = resp_dat;
                memresp_rdy = resp1_rdy;
            end else begin
                resp0_val   = memresp_val;
                resp0_msg   = resp_dat;
                memresp_rdy = resp0_rdy;
            end
        end
        resp_xfer = memresp_val & memresp_rdy;
    end
endmodule

// File: tb/tb_lab2_proc_proc_mem_arbiter.sv
// Bench for the two-requester memory arbiter: scoreboard of owner IDs checks in-order routing.
// Each scenario task drives its own stimulus and compares outputs at the falling edge.
// The bench acts as both requesters and the memory; it never applies backpressure it does not model.
module tb_lab2_proc_proc_mem_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [76:0] req0_msg, req1_msg, memreq_msg;
    logic        memreq_val, memreq_rdy;
    logic        memresp_val, memresp_rdy;
    logic [46:0] memresp_msg, resp0_msg, resp1_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;

    int total = 0;
    int bad   = 0;

    // Reference model: priority bit and queue of expected response owners.
    bit m_prio;
    int exp_id[$];

    lab2_proc_proc_mem_arbiter #(.p_max_outstanding(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_val    (req0_val),
        .req0_rdy    (req0_rdy),
        .req0_msg    (req0_msg),
        .req1_val    (req1_val),
        .req1_rdy    (req1_rdy),
        .req1_msg    (req1_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg),
        .resp0_val   (resp0_val),
        .resp0_rdy   (resp0_rdy),
        .resp0_msg   (resp0_msg),
        .resp1_val   (resp1_val),
        .resp1_rdy   (resp1_rdy),
        .resp1_msg   (resp1_msg)
    );

    always #5 clk = ~clk;

    function automatic logic [76:0] mk_req(input logic [31:0] addr, input logic [31:0] data);
        return {3'd0, 8'h00, addr, 2'd0, data};
    endfunction

    function automatic logic [46:0] mk_resp(input logic [31:0] data);
        return {3'd0, 8'h00, 2'd0, 2'd0, data};
    endfunction

    function automatic int exp_grant();
        if (req0_val && req1_val) return m_prio ? 1 : 0;
        if (req0_val) return 0;
        if (req1_val) return 1;
        return -1;
    endfunction

    // Advance one clock and update the model from the inputs that were applied.
    task automatic tick();
        int g;
        bit push;
        bit pop;
        g    = exp_grant();
        push = (g >= 0) && memreq_rdy && (exp_id.size() < DEPTH) && !reset;
        pop  = memresp_val && !reset && (exp_id.size() > 0) &&
               ((exp_id[0] == 0) ? resp0_rdy : resp1_rdy);
        @(posedge clk);
        if (pop) void'(exp_id.pop_front());
        if (push) begin
            exp_id.push_back(g);
            m_prio = (g == 0);
        end
        #1;
    endtask

    task automatic idle_inputs();
        req0_val    = 1'b0;
        req1_val    = 1'b0;
        req0_msg    = '0;
        req1_msg    = '0;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        memresp_msg = '0;
        resp0_rdy   = 1'b0;
        resp1_rdy   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        m_prio = 1'b0;
        exp_id.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req0_val    = 1'b1;
        req1_val    = 1'b1;
        req0_msg    = mk_req(32'h1, 32'h2);
        req1_msg    = mk_req(32'h3, 32'h4);
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(32'h55);
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({memreq_val, req0_rdy, req1_rdy, memresp_rdy, resp0_val, resp1_val} !== 6'b0) begin
            bad++;
            $display("FAIL reset_val_rdy: got %b want 000000",
                     {memreq_val, req0_rdy, req1_rdy, memresp_rdy, resp0_val, resp1_val});
        end
        total++;
        if (memreq_msg !== 77'd0 || resp0_msg !== 47'd0 || resp1_msg !== 47'd0) begin
            bad++;
            $display("FAIL reset_msgs: got %h/%h/%h want all zero", memreq_msg, resp0_msg, resp1_msg);
        end
        total++;
        if (dut.count !== 3'd0 || dut.prio !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got count=%0d prio=%b want 0/0", dut.count, dut.prio);
        end
        do_reset();
    endtask

    task automatic test_single();
        int id;
        do_reset();
        req0_val   = 1'b1;
        req0_msg   = mk_req(32'h1000, 32'h0000_1234);
        memreq_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (memreq_val !== 1'b1 || memreq_msg !== req0_msg) begin
            bad++;
            $display("FAIL single_fwd: got val=%b msg=%h want 1/%h", memreq_val, memreq_msg, req0_msg);
        end
        total++;
        if ({req0_rdy, req1_rdy} !== 2'b10) begin
            bad++;
            $display("FAIL single_rdy: got %b want 10", {req0_rdy, req1_rdy});
        end
        tick();
        req0_val    = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(32'hCAFE);
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        @(negedge clk);
        total++;
        if (dut.count !== 3'd1) begin
            bad++;
            $display("FAIL single_count1: got %0d want 1", dut.count);
        end
        id = exp_id[0];
        total++;
        if ({resp1_val, resp0_val} !== (id != 0 ? 2'b10 : 2'b01) || memresp_rdy !== 1'b1) begin
            bad++;
            $display("FAIL single_route: got r1r0=%b rdy=%b want id %0d", {resp1_val, resp0_val}, memresp_rdy, id);
        end
        total++;
        if (resp0_msg !== memresp_msg || resp1_msg !== 47'd0) begin
            bad++;
            $display("FAIL single_rmsg: got %h/%h want %h/0", resp0_msg, resp1_msg, memresp_msg);
        end
        tick();
        memresp_val = 1'b0;
        @(negedge clk);
        total++;
        if (dut.count !== 3'd0) begin
            bad++;
            $display("FAIL single_count0: got %0d want 0", dut.count);
        end
    endtask

    task automatic test_alternate();
        int id;
        do_reset();
        memreq_rdy = 1'b1;
        resp0_rdy  = 1'b1;
        resp1_rdy  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req0_val    = (k < 4);
            req1_val    = (k < 4);
            req0_msg    = mk_req(32'h2000 + 32'(k), 32'(k));
            req1_msg    = mk_req(32'h3000 + 32'(k), 32'(k) + 32'h10);
            memresp_val = (k > 0);
            memresp_msg = mk_resp(32'h100 + 32'(k));
            @(negedge clk);
            if (k < 4) begin
                total++;
                if ({req1_rdy, req0_rdy} !== ((k % 2) != 0 ? 2'b10 : 2'b01) ||
                    memreq_msg !== ((k % 2) != 0 ? req1_msg : req0_msg)) begin
                    bad++;
                    $display("FAIL alt_grant%0d: got r1r0=%b msg=%h", k, {req1_rdy, req0_rdy}, memreq_msg);
                end
            end
            if (k > 0) begin
                id = exp_id[0];
                total++;
                if ({resp1_val, resp0_val} !== (((k - 1) % 2) != 0 ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL alt_route%0d: got r1r0=%b want owner %0d", k, {resp1_val, resp0_val}, (k - 1) % 2);
                end
                total++;
                if ((id != 0 ? resp1_msg : resp0_msg) !== memresp_msg ||
                    (id != 0 ? resp0_msg : resp1_msg) !== 47'd0) begin
                    bad++;
                    $display("FAIL alt_rmsg%0d: got %h/%h want owner %0d msg %h", k, resp0_msg, resp1_msg, id, memresp_msg);
                end
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        total++;
        if (dut.count !== 3'd0) begin
            bad++;
            $display("FAIL alt_count: got %0d want 0", dut.count);
        end
    endtask

    task automatic test_full();
        int id;
        do_reset();
        memreq_rdy = 1'b1;
        resp0_rdy  = 1'b1;
        resp1_rdy  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req1_val = 1'b1;
            req1_msg = mk_req(32'h4000 + 32'(k), 32'(k));
            @(negedge clk);
            total++;
            if (req1_rdy !== (k < 4)) begin
                bad++;
                $display("FAIL full_accept%0d: got %b want %b", k, req1_rdy, (k < 4));
            end
            tick();
        end
        memresp_val = 1'b1;
        memresp_msg = mk_resp(32'hF0);
        @(negedge clk);
        total++;
        if (dut.count !== 3'd4 || memresp_rdy !== 1'b1 || resp1_val !== 1'b1) begin
            bad++;
            $display("FAIL full_pop: got count=%0d mrdy=%b r1=%b want 4/1/1", dut.count, memresp_rdy, resp1_val);
        end
        total++;
        if (req1_rdy !== 1'b0 || memreq_val !== 1'b0) begin
            bad++;
            $display("FAIL full_nobypass: got rdy=%b val=%b want 0/0", req1_rdy, memreq_val);
        end
        tick();
        memresp_val = 1'b0;
        @(negedge clk);
        total++;
        if (req1_rdy !== 1'b1 || dut.count !== 3'd3) begin
            bad++;
            $display("FAIL full_after: got rdy=%b count=%0d want 1/3", req1_rdy, dut.count);
        end
        tick();
        req1_val = 1'b0;
        for (int k = 0; k < 4; k++) begin
            memresp_val = 1'b1;
            memresp_msg = mk_resp(32'hD0 + 32'(k));
            @(negedge clk);
            id = exp_id[0];
            total++;
            if ({resp1_val, resp0_val} !== (id != 0 ? 2'b10 : 2'b01) ||
                (id != 0 ? resp1_msg : resp0_msg) !== memresp_msg) begin
                bad++;
                $display("FAIL full_drain%0d: got r1r0=%b want owner %0d", k, {resp1_val, resp0_val}, id);
            end
            tick();
        end
        memresp_val = 1'b0;
        @(negedge clk);
        total++;
        if (dut.count !== 3'd0) begin
            bad++;
            $display("FAIL full_count0: got %0d want 0", dut.count);
        end
    endtask

    task automatic test_resp_stall();
        do_reset();
        memreq_rdy = 1'b1;
        req0_val   = 1'b1;
        req0_msg   = mk_req(32'h5000, 32'h77);
        tick();
        req0_val    = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(32'hBEEF);
        resp0_rdy   = 1'b0;
        resp1_rdy   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (memresp_rdy !== 1'b0 || resp1_val !== 1'b0 || resp0_val !== 1'b1 || dut.count !== 3'd1) begin
                bad++;
                $display("FAIL stall%0d: got mrdy=%b r1=%b r0=%b count=%0d want 0/0/1/1",
                         k, memresp_rdy, resp1_val, resp0_val, dut.count);
            end
            tick();
        end
        resp0_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (memresp_rdy !== 1'b1 || resp0_msg !== memresp_msg) begin
            bad++;
            $display("FAIL stall_release: got mrdy=%b msg=%h want 1/%h", memresp_rdy, resp0_msg, memresp_msg);
        end
        tick();
        memresp_val = 1'b0;
        @(negedge clk);
        total++;
        if (dut.count !== 3'd0) begin
            bad++;
            $display("FAIL stall_count: got %0d want 0", dut.count);
        end
    endtask

    task automatic test_no_ready();
        int id;
        do_reset();
        memreq_rdy = 1'b1;
        req0_val   = 1'b1;
        req0_msg   = mk_req(32'h6000, 32'h1);
        tick();
        req1_val   = 1'b1;
        req1_msg   = mk_req(32'h7000, 32'h2);
        memreq_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({req0_rdy, req1_rdy} !== 2'b00 || memreq_val !== 1'b1 || memreq_msg !== req1_msg) begin
                bad++;
                $display("FAIL noready%0d: got rdy=%b val=%b msg=%h", k, {req0_rdy, req1_rdy}, memreq_val, memreq_msg);
            end
            total++;
            if (dut.prio !== 1'b1 || dut.count !== 3'd1) begin
                bad++;
                $display("FAIL noready_state%0d: got prio=%b count=%0d want 1/1", k, dut.prio, dut.count);
            end
            tick();
        end
        memreq_rdy = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_rdy, req1_rdy} !== 2'b01) begin
            bad++;
            $display("FAIL noready_go: got %b want 01", {req0_rdy, req1_rdy});
        end
        tick();
        req0_val  = 1'b0;
        req1_val  = 1'b0;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            memresp_val = 1'b1;
            memresp_msg = mk_resp(32'hA0 + 32'(k));
            @(negedge clk);
            id = exp_id[0];
            total++;
            if ({resp1_val, resp0_val} !== (id != 0 ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL noready_drain%0d: got r1r0=%b want owner %0d", k, {resp1_val, resp0_val}, id);
            end
            tick();
        end
        memresp_val = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        memreq_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req0_val = 1'b1;
            req1_val = 1'b1;
            req0_msg = mk_req(32'h8000 + 32'(k), 32'(k));
            req1_msg = mk_req(32'h9000 + 32'(k), 32'(k));
            tick();
        end
        req0_val = 1'b0;
        req1_val = 1'b0;
        @(negedge clk);
        total++;
        if (dut.count !== 3'd3) begin
            bad++;
            $display("FAIL mid_count3: got %0d want 3", dut.count);
        end
        @(posedge clk);
        #1;
        reset       = 1'b1;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(32'h5EED);
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        m_prio      = 1'b0;
        exp_id.delete();
        #1;
        total++;
        if (dut.count !== 3'd0 || dut.prio !== 1'b0 || memresp_rdy !== 1'b0 ||
            resp0_val !== 1'b0 || resp1_val !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got count=%0d prio=%b mrdy=%b r0=%b r1=%b want 0/0/0/0/0",
                     dut.count, dut.prio, memresp_rdy, resp0_val, resp1_val);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        req0_val = 1'b1;
        req1_val = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_rdy, req1_rdy} !== 2'b10) begin
            bad++;
            $display("FAIL mid_grant: got %b want 10", {req0_rdy, req1_rdy});
        end
        total++;
        if (memresp_rdy !== 1'b0 || resp0_val !== 1'b0 || resp1_val !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale: got mrdy=%b r0=%b r1=%b want 0/0/0", memresp_rdy, resp0_val, resp1_val);
        end
        memresp_val = 1'b0;
        tick();
        req0_val    = 1'b0;
        req1_val    = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(32'h600D);
        @(negedge clk);
        total++;
        if (resp0_val !== 1'b1 || resp1_val !== 1'b0 || resp0_msg !== memresp_msg) begin
            bad++;
            $display("FAIL mid_route: got r0=%b r1=%b msg=%h want 1/0/%h", resp0_val, resp1_val, resp0_msg, memresp_msg);
        end
        tick();
        memresp_val = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_prio = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_full();
        test_resp_stall();
        test_no_ready();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
